// File: rtl/bypass_ctrl.sv
// bypass_ctrl: hazard and bypass control for the 5-stage 16-bit pipeline.
// Sits in ID. It tracks the destination and write-enable of the two older
// in-flight instructions (in EX and in DM). It registers the EX-stage
// forwarding selects into ID_EX, and it detects load-use hazards, which
// stall IF_ID and put one bubble into ID_EX.
//
// Optional build macro: ZERO_REG_BYP_EN
//   defined   - R0 is hardwired zero. A source address of 0 never matches,
//               so it never bypasses and never causes a load-use stall.
//   undefined - R0 is an ordinary register.
module bypass_ctrl #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rf_re0_ID,
  input  logic              rf_re1_ID,
  input  logic [ADDR_W-1:0] p0_addr_ID,
  input  logic [ADDR_W-1:0] p1_addr_ID,
  input  logic [ADDR_W-1:0] dst_addr_ID,
  input  logic              rf_we_ID,
  input  logic              dm_re_ID,
  input  logic              flush,
  input  logic              stall_ext,
  output logic              byp0_EX,
  output logic              byp1_EX,
  output logic              byp0_DM,
  output logic              byp1_DM,
  output logic              stall_IF_ID,
  output logic              stall_ID_EX,
  output logic              stall_EX_DM,
  output logic              nop_ID_EX
);

  // Tracking state for the instruction in EX (ID_EX) and in DM (EX_DM)
  logic [ADDR_W-1:0] r_dst_ID_EX;
  logic              r_we_ID_EX;
  logic              r_ld_ID_EX;
  logic [ADDR_W-1:0] r_dst_EX_DM;
  logic              r_we_EX_DM;

  // Registered selects handed to the EX-stage source muxes
  logic r_byp0_EX, r_byp1_EX, r_byp0_DM, r_byp1_DM;
  logic r_nop_ID_EX;

  logic w_hit0_EX, w_hit1_EX, w_hit0_DM, w_hit1_DM;
  logic w_p0_ok, w_p1_ok;
  logic w_load_use;
  logic w_bubble;

`ifdef ZERO_REG_BYP_EN
  assign w_p0_ok = (p0_addr_ID != '0);
  assign w_p1_ok = (p1_addr_ID != '0);
`else
  assign w_p0_ok = 1'b1;
  assign w_p1_ok = 1'b1;
`endif

  // Compare the ID source addresses against the two older destinations
  always_comb begin
    w_hit0_EX = rf_re0_ID & w_p0_ok & r_we_ID_EX & (r_dst_ID_EX == p0_addr_ID);
    w_hit1_EX = rf_re1_ID & w_p1_ok & r_we_ID_EX & (r_dst_ID_EX == p1_addr_ID);
    w_hit0_DM = rf_re0_ID & w_p0_ok & r_we_EX_DM & (r_dst_EX_DM == p0_addr_ID);
    w_hit1_DM = rf_re1_ID & w_p1_ok & r_we_EX_DM & (r_dst_EX_DM == p1_addr_ID);
  end

  // A load in EX cannot forward yet, so a consumer in ID must wait one cycle
  assign w_load_use = r_ld_ID_EX & (w_hit0_EX | w_hit1_EX);
  assign w_bubble   = flush | w_load_use;

  assign stall_IF_ID = stall_ext | w_load_use;
  assign stall_ID_EX = stall_ext;
  assign stall_EX_DM = stall_ext;

  // Advance the tracking pipeline; a bubble clears the ID_EX side only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dst_ID_EX <= '0;
      r_we_ID_EX  <= 1'b0;
      r_ld_ID_EX  <= 1'b0;
      r_dst_EX_DM <= '0;
      r_we_EX_DM  <= 1'b0;
      r_byp0_EX   <= 1'b0;
      r_byp1_EX   <= 1'b0;
      r_byp0_DM   <= 1'b0;
      r_byp1_DM   <= 1'b0;
      r_nop_ID_EX <= 1'b0;
    end else if (!stall_ext) begin
      r_we_EX_DM  <= r_we_ID_EX;
      r_dst_EX_DM <= r_dst_ID_EX;
      if (w_bubble) begin
        r_we_ID_EX  <= 1'b0;
        r_ld_ID_EX  <= 1'b0;
        r_byp0_EX   <= 1'b0;
        r_byp1_EX   <= 1'b0;
        r_byp0_DM   <= 1'b0;
        r_byp1_DM   <= 1'b0;
        r_nop_ID_EX <= 1'b1;
      end else begin
        r_dst_ID_EX <= dst_addr_ID;
        r_we_ID_EX  <= rf_we_ID;
        r_ld_ID_EX  <= dm_re_ID;
        r_byp0_EX   <= w_hit0_EX;
        r_byp1_EX   <= w_hit1_EX;
        r_byp0_DM   <= w_hit0_DM;
        r_byp1_DM   <= w_hit1_DM;
        r_nop_ID_EX <= 1'b0;
      end
    end
  end

  assign byp0_EX   = r_byp0_EX;
  assign byp1_EX   = r_byp1_EX;
  assign byp0_DM   = r_byp0_DM;
  assign byp1_DM   = r_byp1_DM;
  assign nop_ID_EX = r_nop_ID_EX;

endmodule

// File: tb/tb_bypass_ctrl.sv
// Testbench for bypass_ctrl. Directed instruction sequences are applied one
// ID cycle at a time. Each cycle pushes its hand-computed expectations onto a
// scoreboard queue, and a monitor pops and compares them on the falling edge.
// The expected registered outputs of a cycle are the ones produced by the
// previous rising edge. The expected stall outputs come from the current ID
// inputs.
module tb_bypass_ctrl;

  logic       clk;
  logic       rst;
  logic       rf_re0_ID, rf_re1_ID;
  logic [3:0] p0_addr_ID, p1_addr_ID, dst_addr_ID;
  logic       rf_we_ID, dm_re_ID, flush, stall_ext;
  logic       byp0_EX, byp1_EX, byp0_DM, byp1_DM;
  logic       stall_IF_ID, stall_ID_EX, stall_EX_DM, nop_ID_EX;

  bypass_ctrl #(.ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .rf_re0_ID(rf_re0_ID), .rf_re1_ID(rf_re1_ID),
    .p0_addr_ID(p0_addr_ID), .p1_addr_ID(p1_addr_ID), .dst_addr_ID(dst_addr_ID),
    .rf_we_ID(rf_we_ID), .dm_re_ID(dm_re_ID), .flush(flush), .stall_ext(stall_ext),
    .byp0_EX(byp0_EX), .byp1_EX(byp1_EX), .byp0_DM(byp0_DM), .byp1_DM(byp1_DM),
    .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX), .stall_EX_DM(stall_EX_DM),
    .nop_ID_EX(nop_ID_EX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         step;
    logic [3:0] byp;   // {byp0_EX, byp1_EX, byp0_DM, byp1_DM}
    logic       nop;
    logic [2:0] stl;   // {stall_IF_ID, stall_ID_EX, stall_EX_DM}
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   step_no = 0;

  // Compares the DUT against the oldest pending expectation each falling edge
  initial begin
    exp_t e;
    logic [3:0] a_byp;
    logic [2:0] a_stl;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a_byp = {byp0_EX, byp1_EX, byp0_DM, byp1_DM};
        a_stl = {stall_IF_ID, stall_ID_EX, stall_EX_DM};
        n_total++;
        if (a_byp === e.byp && nop_ID_EX === e.nop) n_pass++;
        else $display("FAIL regs step %0d: byp=%b nop=%b, expected byp=%b nop=%b",
                      e.step, a_byp, nop_ID_EX, e.byp, e.nop);
        n_total++;
        if (a_stl === e.stl) n_pass++;
        else $display("FAIL stalls step %0d: stall=%b, expected stall=%b",
                      e.step, a_stl, e.stl);
      end
    end
  end

  // One ID cycle: apply inputs just after the rising edge, queue expectations
  task automatic cyc(input logic r, input logic sx, input logic fl,
                     input logic re0, input logic re1,
                     input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] dst,
                     input logic we, input logic ld,
                     input logic [3:0] eb, input logic en, input logic [2:0] es);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stall_ext = sx; flush = fl;
    rf_re0_ID = re0; rf_re1_ID = re1;
    p0_addr_ID = p0; p1_addr_ID = p1; dst_addr_ID = dst;
    rf_we_ID = we; dm_re_ID = ld;
    step_no++;
    e.step = step_no; e.byp = eb; e.nop = en; e.stl = es;
    exp_q.push_back(e);
  endtask

  // Inputs: r sx fl re0 re1 p0 p1 dst we ld | expected: byp nop stall
  initial begin
    rst = 1'b1; stall_ext = 1'b0; flush = 1'b0;
    rf_re0_ID = 1'b0; rf_re1_ID = 1'b0;
    p0_addr_ID = '0; p1_addr_ID = '0; dst_addr_ID = '0;
    rf_we_ID = 1'b0; dm_re_ID = 1'b0;

    // Reset state; stall outputs follow stall_ext while in reset
    cyc(1,0,0, 0,0, 0,0,0, 0,0, 4'b0000,0,3'b000);
    cyc(1,1,0, 0,0, 0,0,0, 0,0, 4'b0000,0,3'b111);

    // ADD R3 then SUB R5,R3,R4: EX bypass on port 0
    cyc(0,0,0, 1,1, 1,2,3, 1,0, 4'b0000,0,3'b000);
    cyc(0,0,0, 1,1, 3,4,5, 1,0, 4'b0000,0,3'b000);
    cyc(0,0,0, 0,0, 0,0,0, 0,0, 4'b1000,0,3'b000);

    // ADD R3, NOP, SUB R5,R4,R3: DM bypass on port 1
    cyc(0,0,0, 1,1, 1,2,3, 1,0, 4'b0000,0,3'b000);
    cyc(0,0,0, 0,0, 0,0,0, 0,0, 4'b0000,0,3'b000);
    cyc(0,0,0, 1,1, 4,3,5, 1,0, 4'b0000,0,3'b000);
    cyc(0,0,0, 0,0, 0,0,0, 0,0, 4'b0001,0,3'b000);

    // LW R2 then ADD R6,R2,R2: one load-use bubble, then DM bypass on both ports
    cyc(0,0,0, 1,0, 1,0,2, 1,1, 4'b0000,0,3'b000);
    cyc(0,0,0, 1,1, 2,2,6, 1,0, 4'b0000,0,3'b100);
    cyc(0,0,0, 1,1, 2,2,6, 1,0, 4'b0000,1,3'b000);
    cyc(0,0,0, 0,0, 0,0,0, 0,0, 4'b0011,0,3'b000);

    // ADD R7 twice then SUB R1,R7,R0: EX and DM selects both set
    cyc(0,0,0, 1,1, 1,1,7, 1,0, 4'b0000,0,3'b000);
    cyc(0,0,0, 1,1, 1,1,7, 1,0, 4'b0000,0,3'b000);
    cyc(0,0,0, 1,1, 7,0,1, 1,0, 4'b0000,0,3'b000);
    cyc(0,0,0, 0,0, 0,0,0, 0,0, 4'b1010,0,3'b000);

    // LW R2, then ADD R6,R2,R2 in ID with flush: bubble, stall_IF_ID still up
    cyc(0,0,0, 1,0, 4,0,2, 1,1, 4'b0000,0,3'b000);
    cyc(0,0,1, 1,1, 2,2,6, 1,0, 4'b0000,0,3'b100);
    cyc(0,0,0, 0,0, 0,0,0, 0,0, 4'b0000,1,3'b000);

    // Flush alone (no load-use) still bubbles and suppresses the EX hit
    cyc(0,0,0, 1,1, 1,2,3, 1,0, 4'b0000,0,3'b000);
    cyc(0,0,1, 1,1, 3,4,5, 1,0, 4'b0000,0,3'b000);
    cyc(0,0,0, 0,0, 0,0,0, 0,0, 4'b0000,1,3'b000);

    // byp0_EX held through three stall_ext cycles, then reset clears it
    cyc(0,0,0, 1,1, 1,2,3, 1,0, 4'b0000,0,3'b000);
    cyc(0,0,0, 1,1, 3,4,5, 1,0, 4'b0000,0,3'b000);
    cyc(0,1,0, 0,0, 0,0,0, 0,0, 4'b1000,0,3'b111);
    cyc(0,1,0, 0,0, 0,0,0, 0,0, 4'b1000,0,3'b111);
    cyc(0,1,0, 0,0, 0,0,0, 0,0, 4'b1000,0,3'b111);
    cyc(1,0,0, 0,0, 0,0,0, 0,0, 4'b0000,0,3'b000);
    cyc(1,1,0, 0,0, 0,0,0, 0,0, 4'b0000,0,3'b111);

    // Reset during a pending load-use removes the stall at once
    cyc(0,0,0, 1,0, 4,0,2, 1,1, 4'b0000,0,3'b000);
    cyc(0,0,0, 1,1, 2,2,6, 1,0, 4'b0000,0,3'b100);
    cyc(1,0,0, 1,1, 2,2,6, 1,0, 4'b0000,0,3'b000);

    // Matching addresses without read enables, then a write three back: no bypass
    cyc(0,0,0, 1,1, 1,2,3, 1,0, 4'b0000,0,3'b000);
    cyc(0,0,0, 0,0, 3,3,9, 0,0, 4'b0000,0,3'b000);
    cyc(0,0,0, 0,0, 0,0,0, 0,0, 4'b0000,0,3'b000);
    cyc(0,0,0, 1,1, 3,3,5, 1,0, 4'b0000,0,3'b000);
    cyc(0,0,0, 0,0, 0,0,0, 0,0, 4'b0000,0,3'b000);

    // ADD R0 then SUB R1,R0,R0
    cyc(0,0,0, 1,1, 1,1,0, 1,0, 4'b0000,0,3'b000);
    cyc(0,0,0, 1,1, 0,0,1, 1,0, 4'b0000,0,3'b000);
`ifdef ZERO_REG_BYP_EN
    cyc(0,0,0, 0,0, 0,0,0, 0,0, 4'b0000,0,3'b000);
`else
    cyc(0,0,0, 0,0, 0,0,0, 0,0, 4'b1100,0,3'b000);
`endif

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bypass_ctrl.md
Name: bypass_ctrl

Overview:
- Hazard and bypass control for the 5-stage 16-bit CPU pipeline. Sits in ID and produces the forwarding selects consumed by the EX-stage source muxes.
- Tracks destination register and write-enable of the two older in-flight instructions. Compares them against the ID source addresses, registers the bypass selects into ID_EX, and detects load-use hazards. On a load-use hazard it stalls IF_ID and inserts a bubble into ID_EX.

Parameters:
- ADDR_W, 4, register-file address width (16 registers).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rf_re0_ID  in  1  instruction in ID reads port 0
- rf_re1_ID  in  1  instruction in ID reads port 1
- p0_addr_ID  in  ADDR_W  port 0 source register
- p1_addr_ID  in  ADDR_W  port 1 source register
- dst_addr_ID  in  ADDR_W  destination register of instruction in ID
- rf_we_ID  in  1  instruction in ID writes the RF
- dm_re_ID  in  1  instruction in ID is a load (LW)
- flush  in  1  taken branch/jump; instruction in ID is killed
- stall_ext  in  1  global freeze (memory wait)
- byp0_EX, byp1_EX  out  1  EX-stage src selects dst_EX_DM for port 0/1 (registered)
- byp0_DM, byp1_DM  out  1  EX-stage src selects dst_DM_WB for port 0/1 (registered)
- stall_IF_ID  out  1  hold PC and IF_ID
- stall_ID_EX  out  1  hold ID_EX flops
- stall_EX_DM  out  1  hold EX_DM flops
- nop_ID_EX  out  1  instruction now in EX is a bubble (registered)

Behaviour:
- Internal tracking flops:
  - dst_ID_EX, we_ID_EX, ld_ID_EX for the instruction in EX.
  - dst_EX_DM, we_EX_DM for the instruction in DM.
- Combinational match terms in ID, for n = 0, 1:
  - hitn_EX = rf_ren_ID & we_ID_EX & (dst_ID_EX == pn_addr_ID)
  - hitn_DM = rf_ren_ID & we_EX_DM & (dst_EX_DM == pn_addr_ID)
- load_use = ld_ID_EX & (hit0_EX | hit1_EX). Combinational.
- Stall outputs, all combinational:
  - stall_IF_ID = stall_ext | load_use
  - stall_ID_EX = stall_ext
  - stall_EX_DM = stall_ext
- Reset (rst=1, async): all tracking flops, byp*, and nop_ID_EX are 0. Stall outputs then equal stall_ext.
- Clock edge with stall_ext=1: every flop holds, including byp* and nop_ID_EX.
- Clock edge with stall_ext=0, bubble case (flush | load_use):
  - we_ID_EX=0, ld_ID_EX=0, all byp*=0, nop_ID_EX=1, dst_ID_EX don't-care.
  - flush has priority over load_use; the resulting state is identical.
- Clock edge with stall_ext=0, otherwise:
  - we_ID_EX=rf_we_ID, ld_ID_EX=dm_re_ID, dst_ID_EX=dst_addr_ID.
  - bypn_EX=hitn_EX, bypn_DM=hitn_DM, nop_ID_EX=0.
- EX_DM advance (stall_ext=0): we_EX_DM=we_ID_EX, dst_EX_DM=dst_ID_EX, regardless of bubble.
- Priority: bypn_EX and bypn_DM may both be 1. The consumer gives EX priority (most recent data); this block does not mask DM.
- Latency:
  - Bypass selects are valid the cycle after the ID decision, aligned with the ID_EX-registered operands.
  - load_use costs exactly one bubble. On the next cycle the load sits in DM and is picked up via bypn_DM.
- Writes three or more instructions older are resolved by RF write-before-read; no bypass is generated.
- rst asserted mid-stall or mid-bubble clears immediately; no pending stall survives reset.

Optional Feature:
- Macro ZERO_REG_BYP_EN.
- Defined: R0 is hardwired zero. Any match term whose source address is 0 is forced to 0, so reads of R0 never bypass and never cause load_use.
- Undefined: R0 is treated as an ordinary register.

Test Plan:
- ADD R3 then SUB R5,R3,R4 back-to-back -> cycle after SUB is in ID: byp0_EX=1, byp0_DM=0, others 0; no stall.
- ADD R3, NOP, SUB R5,R4,R3 -> byp1_DM=1, byp1_EX=0; no stall.
- LW R2 then ADD R6,R2,R2 -> load_use=1 one cycle: stall_IF_ID=1, nop_ID_EX=1 next edge. Following cycle byp0_DM=byp1_DM=1, byp*_EX=0.
- ADD R7 twice then SUB R1,R7,R0 -> byp0_EX=1 and byp0_DM=1 both set.
- LW R2 followed by flush with ADD R6,R2,R2 in ID -> bubble inserted, nop_ID_EX=1, stall_IF_ID still asserted that cycle. No byp set.
- stall_ext=1 for 3 cycles with byp0_EX=1 -> byp0_EX held 1, all stall outputs 1. Assert rst during this -> all outputs 0 immediately.
- With ZERO_REG_BYP_EN: ADD R0 then SUB R1,R0,R0 -> all byp*=0.
